rst_sequencer: RTL and testbench

- Replaces ad-hoc reset feedback loops with a fully registered reset controller. There are no combinational loops and no async-set flops.
- Collects reset requests from N_REQ asynchronous level sources and holds all N_DOM downstream reset domains asserted for a guaranteed minimum stretch.
- Releases the domains one at a time, in index order, with a ready handshake per domain.
- Sits at the top of the FPGA design, between the board-level reset sources and the functional blocks.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_req_sync.sv | 29 ++
 rtl/rst_sequencer.sv | 132 +++++++++++++
 tb/tb_rst_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encoding and a width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/rst_req_sync.sv
// Multi-bit, multi-stage level synchronizer for asynchronous reset requests.
module rst_req_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Registered reset controller: stretches reset after the last request, then
// releases the domains one by one, each gated by its ready handshake.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int N_DOM       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] req_mask_i,
  input  logic [N_DOM-1:0] dom_ready_i,
  input  logic             cause_clr_i,
  output logic [N_DOM-1:0] dom_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [N_REQ-1:0] cause_o
);

  localparam int STRETCH_W = clog2(STRETCH + 1);
  localparam int TO_W      = clog2(ACK_TIMEOUT + 1);
  localparam int K_W       = (N_DOM > 1) ? clog2(N_DOM) : 1;
  localparam logic [N_DOM-1:0] ALL_ONES = '1;

  state_t               state;
  logic [K_W-1:0]       k;
  logic [STRETCH_W-1:0] stretch_cnt;
  logic [TO_W-1:0]      to_cnt;
  logic [N_REQ-1:0]     req_sync;
  logic [N_REQ-1:0]     eff;
  logic                 any_req;
  logic                 ready_k;
  logic                 to_done;
  logic                 timeout_hit;

  rst_req_sync #(
    .WIDTH  (N_REQ),
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_i),
    .q     (req_sync)
  );

  // Masking after the synchronizer keeps the mask a purely synchronous control.
  assign eff         = req_sync & ~req_mask_i;
  assign any_req     = |eff;
  assign ready_k     = dom_ready_i[k];
  assign to_done     = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
  assign timeout_hit = (state == ST_RELEASE) && !ready_k && to_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ASSERT;
      k           <= '0;
      stretch_cnt <= '0;
      to_cnt      <= '0;
      dom_rst_o   <= ALL_ONES;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      cause_o     <= '0;
    end else begin
      // Sticky flags: a set in the same cycle as a clear wins.
      cause_o <= eff | (cause_clr_i ? {N_REQ{1'b0}} : cause_o);
      if (timeout_hit) begin
        timeout_o <= 1'b1;
      end else if (cause_clr_i) begin
        timeout_o <= 1'b0;
      end

      if (any_req && state != ST_ASSERT) begin
        state       <= ST_ASSERT;
        k           <= '0;
        stretch_cnt <= '0;
        to_cnt      <= '0;
        dom_rst_o   <= ALL_ONES;
        busy_o      <= 1'b1;
        done_o      <= 1'b0;
      end else begin
        case (state)
          ST_ASSERT: begin
            dom_rst_o <= ALL_ONES;
            if (any_req) begin
              stretch_cnt <= '0;
            end else if (stretch_cnt == STRETCH_W'(STRETCH - 1)) begin
              state       <= ST_RELEASE;
              k           <= '0;
              to_cnt      <= '0;
              stretch_cnt <= '0;
              dom_rst_o   <= ALL_ONES << 1;
            end else if (stretch_cnt != {STRETCH_W{1'b1}}) begin
              stretch_cnt <= stretch_cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            // Lower domains are already released, so a left shift frees domain k+1.
            if (ready_k || to_done) begin
              to_cnt    <= '0;
              dom_rst_o <= dom_rst_o << 1;
              if (k == K_W'(N_DOM - 1)) begin
                state  <= ST_RUN;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            dom_rst_o <= '0;
          end
          default: begin
            state     <= ST_ASSERT;
            dom_rst_o <= ALL_ONES;
            busy_o    <= 1'b1;
            done_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: vector table, corner-case sequences and random
// stimulus, all checked every cycle against a timestamp-based reference model.
module tb_rst_sequencer;

  localparam int N_REQ   = 4;
  localparam int N_DOM   = 3;
  localparam int SYNC    = 2;
  localparam int STRETCH = 16;
  localparam int ACK     = 255;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] mask = '0;
  logic [N_DOM-1:0] ready = '1;
  logic             clr = 1'b0;
  logic [N_DOM-1:0] dom_rst;
  logic             busy;
  logic             done;
  logic             tmo;
  logic [N_REQ-1:0] cause;

  int total = 0;
  int bad   = 0;

  rst_sequencer #(
    .N_REQ       (N_REQ),
    .N_DOM       (N_DOM),
    .SYNC_STAGES (SYNC),
    .STRETCH     (STRETCH),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req),
    .req_mask_i  (mask),
    .dom_ready_i (ready),
    .cause_clr_i (clr),
    .dom_rst_o   (dom_rst),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (tmo),
    .cause_o     (cause)
  );

  always #5 clk = ~clk;

  // Reference model: phase flag, count of acknowledged domains, and the
  // edge numbers of the last request and of the start of the current wait.
  logic [N_REQ-1:0] m_sync [SYNC];
  bit               m_assert = 1'b1;
  int               m_acked = 0;
  int               m_cyc = 0;
  int               m_last_req = 0;
  int               m_wait_start = 0;
  logic             m_tmo = 1'b0;
  logic [N_REQ-1:0] m_cause = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [N_DOM-1:0] m_dom();
    logic [N_DOM-1:0] v;
    int rel;
    v = '1;
    if (m_assert) return v;
    rel = (m_acked + 1 > N_DOM) ? N_DOM : m_acked + 1;
    return v << rel;
  endfunction

  task automatic model_edge();
    logic [N_REQ-1:0] eff;
    bit tmo_evt;
    m_cyc++;
    if (reset) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = '0;
      m_assert   = 1'b1;
      m_acked    = 0;
      m_last_req = m_cyc;
      m_cause    = '0;
      m_tmo      = 1'b0;
    end else begin
      eff = m_sync[SYNC-1] & ~mask;
      tmo_evt = !m_assert && (m_acked < N_DOM) && !ready[m_acked] &&
                (m_cyc - m_wait_start >= ACK);
      m_cause = eff | (clr ? '0 : m_cause);
      if (tmo_evt) m_tmo = 1'b1;
      else if (clr) m_tmo = 1'b0;
      if (eff != '0) begin
        m_assert   = 1'b1;
        m_acked    = 0;
        m_last_req = m_cyc;
      end else if (m_assert) begin
        if (m_cyc - m_last_req >= STRETCH) begin
          m_assert     = 1'b0;
          m_acked      = 0;
          m_wait_start = m_cyc;
        end
      end else if (m_acked < N_DOM) begin
        if (ready[m_acked] || (m_cyc - m_wait_start >= ACK)) begin
          m_acked++;
          m_wait_start = m_cyc;
        end
      end
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = req;
    end
  endtask

  task automatic step();
    logic m_run;
    @(posedge clk);
    model_edge();
    #1;
    m_run = !m_assert && (m_acked == N_DOM);
    check("model", {dom_rst, busy, done, tmo, cause},
          {m_dom(), !m_run, m_run, m_tmo, m_cause});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(input string name, input logic [N_DOM-1:0] e_dom,
                            input logic e_busy, input logic e_done,
                            input logic e_tmo, input logic [N_REQ-1:0] e_cause);
    check(name, {dom_rst, busy, done, tmo, cause}, {e_dom, e_busy, e_done, e_tmo, e_cause});
  endtask

  typedef struct {
    int               n;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic [N_DOM-1:0] rdy;
    logic             clr;
    logic [N_DOM-1:0] e_dom;
    logic             e_busy;
    logic             e_done;
    logic             e_tmo;
    logic [N_REQ-1:0] e_cause;
  } vec_t;

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < SYNC; i++) m_sync[i] = '0;

    // Power-up sequence, a request from RUN, a masked request, cause clear.
    vecs[0]  = '{2,  1'b1, 4'h0, 4'h0, 3'b111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[1]  = '{15, 1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[2]  = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[3]  = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[4]  = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 4'h0};
    vecs[5]  = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[6]  = '{2,  1'b0, 4'h4, 4'h0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'h0};
    vecs[7]  = '{3,  1'b0, 4'h4, 4'h0, 3'b111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 4'h4};
    vecs[8]  = '{17, 1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 4'h4};
    vecs[9]  = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 4'h4};
    vecs[10] = '{3,  1'b0, 4'h0, 4'h0, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'h4};
    vecs[11] = '{4,  1'b0, 4'h1, 4'h1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'h4};
    vecs[12] = '{3,  1'b0, 4'h0, 4'h1, 3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 4'h4};
    vecs[13] = '{1,  1'b0, 4'h0, 4'h0, 3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 4'h0};

    for (int i = 0; i < 14; i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      mask  = vecs[i].mask;
      ready = vecs[i].rdy;
      clr   = vecs[i].clr;
      run(vecs[i].n);
      expect_out($sformatf("vec%0d", i), vecs[i].e_dom, vecs[i].e_busy,
                 vecs[i].e_done, vecs[i].e_tmo, vecs[i].e_cause);
    end
    clr = 1'b0;

    // Domain 1 never acknowledges: 255-cycle wait, then timeout and advance.
    reset = 1'b1; ready = 3'b101;
    run(2);
    reset = 1'b0;
    run(271);
    expect_out("to_wait", 3'b100, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    expect_out("to_fire", 3'b000, 1'b1, 1'b0, 1'b1, 4'h0);
    step();
    expect_out("to_run", 3'b000, 1'b0, 1'b1, 1'b1, 4'h0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    expect_out("to_clr", 3'b000, 1'b0, 1'b1, 1'b0, 4'h0);

    // Request arriving on the same edge as ready[0] in RELEASE(0).
    reset = 1'b1; ready = 3'b000;
    run(2);
    reset = 1'b0;
    run(16);
    expect_out("rel0", 3'b110, 1'b1, 1'b0, 1'b0, 4'h0);
    req = 4'h8;
    run(2);
    ready = 3'b001;
    step();
    expect_out("race_req", 3'b111, 1'b1, 1'b0, 1'b0, 4'h8);
    req = 4'h0; ready = 3'b000;
    run(5);
    expect_out("race_hold", 3'b111, 1'b1, 1'b0, 1'b0, 4'h8);

    // Synchronous reset while waiting in RELEASE(1).
    ready = 3'b101;
    run(30);
    expect_out("rel1", 3'b100, 1'b1, 1'b0, 1'b0, 4'h8);
    reset = 1'b1;
    step();
    expect_out("mid_reset", 3'b111, 1'b1, 1'b0, 1'b0, 4'h0);
    reset = 1'b0; ready = 3'b111;
    run(15);
    expect_out("restart_hold", 3'b111, 1'b1, 1'b0, 1'b0, 4'h0);
    step();
    expect_out("restart_rel", 3'b110, 1'b1, 1'b0, 1'b0, 4'h0);
    run(3);
    expect_out("restart_run", 3'b000, 1'b0, 1'b1, 1'b0, 4'h0);

    // Randomized traffic, with periodic stalls of the ready handshakes.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) req = N_REQ'($urandom_range(1, 15));
      else if ($urandom_range(0, 3) == 0) req = '0;
      if ($urandom_range(0, 149) == 0) mask = N_REQ'($urandom_range(0, 15));
      if ((c / 600) % 3 == 2) ready = N_DOM'($urandom_range(0, 7)) & 3'b101;
      else ready = N_DOM'($urandom_range(0, 7));
      clr = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
